// File: rtl/byte_word_packer_pkg.sv
// Shared types and helpers for the byte-to-word packer.
// BYTE_WORD_PACKER_PARITY_EN adds a stored parity bit to each FIFO entry.
package byte_word_packer_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
        logic              partial;
`ifdef BYTE_WORD_PACKER_PARITY_EN
        logic              parity;
`endif
    } pack_entry_t;

    function automatic logic word_parity(input logic [WORD_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/byte_word_fifo.sv
// Synchronous FIFO of packed words with occupancy count and synchronous active-low reset.
module byte_word_fifo
    import byte_word_packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  pack_entry_t                push_entry,
    input  logic                       pop,
    output pack_entry_t                head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    pack_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full      = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Entry storage; contents need no reset because the head is gated by empty downstream.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 16-bit words buffered in a FIFO; data reads zero when no word is valid.
// BYTE_WORD_PACKER_PARITY_EN adds the out_parity port.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BYTE_W-1:0]          in_byte,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W-1:0]          data,
    output logic                       out_last,
    output logic                       out_partial,
`ifdef BYTE_WORD_PACKER_PARITY_EN
    output logic                       out_parity,
`endif
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    pack_state_e        state_r;
    logic [BYTE_W-1:0]  held_r;
    logic               run_r;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    pack_entry_t        push_entry_s;
    pack_entry_t        head_s;

    assign in_ready  = run_r && !full_s;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = !empty_s;
    assign pop_s     = out_valid && out_ready;

    // Form the word to push for the byte being accepted this cycle.
    always_comb begin
        push_s       = 1'b0;
        push_entry_s = '0;
        if (accept_s && (state_r == HALF)) begin
            push_s               = 1'b1;
            push_entry_s.data    = BIG_ENDIAN ? {held_r, in_byte} : {in_byte, held_r};
            push_entry_s.last    = in_last;
            push_entry_s.partial = 1'b0;
        end else if (accept_s && in_last) begin
            // Lone final byte sits in the first-byte lane, other lane zero.
            push_s               = 1'b1;
            push_entry_s.data    = BIG_ENDIAN ? {in_byte, {BYTE_W{1'b0}}} : {{BYTE_W{1'b0}}, in_byte};
            push_entry_s.last    = 1'b1;
            push_entry_s.partial = 1'b1;
        end else begin
            push_s = 1'b0;
        end
`ifdef BYTE_WORD_PACKER_PARITY_EN
        push_entry_s.parity = word_parity(push_entry_s.data);
`endif
    end

    // Pairing FSM and the run flag that holds off input for one cycle after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= EMPTY;
            held_r  <= {BYTE_W{1'b0}};
            run_r   <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (accept_s) begin
                case (state_r)
                    EMPTY: begin
                        if (!in_last) begin
                            held_r  <= in_byte;
                            state_r <= HALF;
                        end else begin
                            state_r <= EMPTY;
                        end
                    end
                    HALF:    state_r <= EMPTY;
                    default: state_r <= EMPTY;
                endcase
            end
        end
    end

    byte_word_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s),
        .level      (fifo_level)
    );

    // Head fields are forced to zero whenever no word is valid.
    always_comb begin
        data        = {WORD_W{1'b0}};
        out_last    = 1'b0;
        out_partial = 1'b0;
`ifdef BYTE_WORD_PACKER_PARITY_EN
        out_parity  = 1'b0;
`endif
        if (out_valid) begin
            data        = head_s.data;
            out_last    = head_s.last;
            out_partial = head_s.partial;
`ifdef BYTE_WORD_PACKER_PARITY_EN
            out_parity  = head_s.parity;
`endif
        end else begin
            data = {WORD_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Randomised and directed bench for byte_word_packer against a queue-based reference model.
module tb_byte_word_packer;

    localparam int DEPTH      = 4;
    localparam bit BIG_ENDIAN = 1'b0;
    localparam int LVL_W      = $clog2(DEPTH+1);

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_byte;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      data;
    logic             out_last;
    logic             out_partial;
`ifdef BYTE_WORD_PACKER_PARITY_EN
    logic             out_parity;
`endif
    logic [LVL_W-1:0] fifo_level;

    byte_word_packer #(
        .DEPTH      (DEPTH),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data        (data),
        .out_last    (out_last),
        .out_partial (out_partial),
`ifdef BYTE_WORD_PACKER_PARITY_EN
        .out_parity  (out_parity),
`endif
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        p;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] pend_q[$];
    logic       m_run = 1'b0;
    logic       last_acc = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected word built from the bytes of one pair (or a lone final byte).
    function automatic word_t make_word(input logic [7:0] b[$], input logic is_last);
        word_t w;
        if (b.size() == 2) begin
            w.d = BIG_ENDIAN ? {b[0], b[1]} : {b[1], b[0]};
            w.p = 1'b0;
        end else begin
            w.d = BIG_ENDIAN ? {b[0], 8'h00} : {8'h00, b[0]};
            w.p = 1'b1;
        end
        w.l = is_last;
        return w;
    endfunction

    task automatic compare_all();
        logic        ev;
        logic [15:0] ed;
        logic        el;
        logic        ep;
        ev = (exp_q.size() != 0);
        ed = ev ? exp_q[0].d : 16'h0;
        el = ev ? exp_q[0].l : 1'b0;
        ep = ev ? exp_q[0].p : 1'b0;
        check("out_valid", {31'd0, out_valid}, {31'd0, ev});
        check("data", {16'd0, data}, {16'd0, ed});
        check("out_last", {31'd0, out_last}, {31'd0, el});
        check("out_partial", {31'd0, out_partial}, {31'd0, ep});
        check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
        check("in_ready", {31'd0, in_ready}, {31'd0, (m_run && exp_q.size() < DEPTH)});
`ifdef BYTE_WORD_PACKER_PARITY_EN
        check("out_parity", {31'd0, out_parity}, {31'd0, (ev ? ^ed : 1'b0)});
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic v, input logic [7:0] b, input logic l,
                        input logic ordy, input logic rstn);
        logic acc;
        in_valid  = v;
        in_byte   = b;
        in_last   = l;
        out_ready = ordy;
        reset_n   = rstn;
        acc = 1'b0;
        if (!rstn) begin
            exp_q.delete();
            pend_q.delete();
            m_run = 1'b0;
        end else begin
            acc = v && m_run && (exp_q.size() < DEPTH);
            if (exp_q.size() != 0 && ordy) begin
                void'(exp_q.pop_front());
            end
            if (acc) begin
                pend_q.push_back(b);
                if (pend_q.size() == 2 || l) begin
                    exp_q.push_back(make_word(pend_q, l));
                    pend_q.delete();
                end
            end
            m_run = 1'b1;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int   idx;
        int   cyc;
        logic seen_full;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b0;

        // Reset and release
        repeat (3) step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
        check("rdy_first_cycle", {31'd0, in_ready}, 32'd1);
        check("no_word_after_release", {16'd0, data}, 32'h0);

        // Pair AA,BB
        step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'hBB, 1'b1, 1'b1, 1'b1);
        check("pair_data", {16'd0, data}, 32'h0000_BBAA);
        check("pair_last", {31'd0, out_last}, 32'd1);
        check("pair_partial", {31'd0, out_partial}, 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Single final byte
        step(1'b1, 8'h5C, 1'b1, 1'b1, 1'b1);
        check("single_data", {16'd0, data}, 32'h0000_005C);
        check("single_partial", {31'd0, out_partial}, 32'd1);
        check("single_last", {31'd0, out_last}, 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Back-pressure: 2*DEPTH+1 bytes with out_ready low, then released
        idx = 0;
        cyc = 0;
        seen_full = 1'b0;
        while (idx < 2*DEPTH+1 && cyc < 200) begin
            step(1'b1, 8'h40 + 8'(idx), (idx == 2*DEPTH), (cyc >= 2*DEPTH + 4), 1'b1);
            if (last_acc) idx++;
            cyc++;
            if (!seen_full && exp_q.size() == DEPTH) begin
                seen_full = 1'b1;
                check("level_full", 32'(fifo_level), DEPTH);
                check("rdy_full", {31'd0, in_ready}, 32'd0);
            end
        end
        check("stream_accepted", idx, 2*DEPTH+1);
        check("saw_full", {31'd0, seen_full}, 32'd1);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
            cyc++;
        end
        check("drained", {31'd0, out_valid}, 32'd0);

        // Reset while holding a byte with two words queued
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h04, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        check("pre_reset_level", 32'(fifo_level), 32'd2);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("mid_reset_level", 32'(fifo_level), 32'd0);
        check("mid_reset_data", {16'd0, data}, 32'h0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h33, 1'b1, 1'b1, 1'b1);
        check("post_reset_pair", {16'd0, data}, 32'h0000_3322);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

`ifdef BYTE_WORD_PACKER_PARITY_EN
        step(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
        check("parity_0001", {31'd0, out_parity}, 32'd1);
        step(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        check("parity_0003", {31'd0, out_parity}, 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
Upstream feeder for the 16-bit `data` bus consumed by the assertion-checked monitor stage. It packs an 8-bit valid/ready byte stream into 16-bit words and buffers them in a small FIFO. It presents words on `data` with a valid/ready handshake. `data` is forced to 16'h0 whenever no word is valid, so the downstream "data == 0 after reset rises" property holds by construction.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
BIG_ENDIAN, 0, 0: first byte goes to data[7:0]; 1: first byte goes to data[15:8].

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  synchronous, active-low reset.
in_valid  input  1  byte valid.
in_ready  output  1  byte accepted on in_valid && in_ready.
in_byte  input  8  byte payload.
in_last  input  1  marks the final byte of a message.
out_valid  output  1  word available.
out_ready  input  1  word consumed on out_valid && out_ready.
data  output  16  packed word; 16'h0 when out_valid == 0.
out_last  output  1  word contains the final byte of a message.
out_partial  output  1  only the first-byte lane is valid; the other lane is 8'h00.
fifo_level  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (reset_n low at a clk edge):
  - FSM goes to EMPTY; the held byte is discarded; the FIFO is cleared; run_q is cleared.
  - Outputs: in_ready=0, out_valid=0, data=0, out_last=0, out_partial=0, fifo_level=0.
- run_q is set on the first edge with reset_n high. Therefore in_ready stays 0 for exactly one cycle after reset release.
- in_ready = run_q && !full. It is purely combinational from registers and does not depend on in_valid.
- FSM EMPTY:
  - Accept with in_last=0: store the byte; go to HALF.
  - Accept with in_last=1: push the word {lane1=0, lane0=byte} with last=1, partial=1; stay in EMPTY.
- FSM HALF:
  - Accept: push {held, byte} ordered per BIG_ENDIAN, with last=in_last, partial=0; go to EMPTY.
- No accept: state and the held byte are unchanged.
- Latency: a pushed word appears on out_valid/data the cycle after the accepting edge, with no bypass.
- FIFO:
  - Entry fields: {data, last, partial}.
  - Push and pop in the same cycle: level unchanged.
  - Pointers wrap modulo DEPTH.
  - When full, in_ready=0. A byte is never dropped.
- Output:
  - out_valid = !empty.
  - When valid, data, out_last and out_partial come from the head entry; otherwise all are 0.
  - Head fields must stay stable while out_valid && !out_ready.
- Reset asserted mid-message or mid-transfer: all state is lost and no partial word is emitted.
- in_last asserted on the second byte of a pair produces a normal full word with last=1.

Optional Feature:
BYTE_WORD_PACKER_PARITY_EN
- Defined:
  - Adds output port out_parity (1 bit), the even parity (XOR) of the 16-bit word.
  - Parity is computed at push and stored in the FIFO entry.
  - out_parity is 0 when out_valid=0 and 0 in reset.
- Undefined: the port and the storage bit are absent; behaviour is otherwise identical.

Decomposition:
- Package byte_word_packer_pkg contains:
  - pack_state_e enum {EMPTY, HALF};
  - pack_entry_t struct {logic [15:0] data; logic last; logic partial; optional parity};
  - localparam BYTE_W=8, WORD_W=16.
- One sub-module, byte_word_fifo, is natural: a parameterised synchronous FIFO over pack_entry_t. It has push/pop/full/empty/level and a synchronous active-low reset.

Test Plan:
- Reset release, out_ready=1:
  - data==0 and out_valid==0 throughout reset.
  - in_ready==0 for one cycle after release, then 1.
- Bytes 8'hAA, 8'hBB (last), BIG_ENDIAN=0 -> one word data=16'hBBAA, out_last=1, out_partial=0, valid the cycle after 8'hBB is accepted.
- Single byte 8'h5C with in_last -> data=16'h005C, out_partial=1, out_last=1.
- out_ready=0, stream 2*DEPTH+1 bytes:
  - fifo_level reaches DEPTH; in_ready drops; the next byte is held.
  - Release out_ready: all words arrive in order with no loss.
- Reset asserted while in HALF holding 8'h11 and FIFO at level 2 -> next cycle level=0, data=0. The following pair 8'h22, 8'h33 yields 16'h3322 (no 8'h11).
- With BYTE_WORD_PACKER_PARITY_EN, word 16'h0001 -> out_parity=1; word 16'h0003 -> out_parity=0.
